// File: rtl/cpc_ram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : cpc_ram_pkg
// Brief    : Shared types and constants for the 512K CPC RAM bank controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package cpc_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] MODE_0 = 3'd0;
    localparam logic [2:0] MODE_1 = 3'd1;
    localparam logic [2:0] MODE_2 = 3'd2;
    localparam logic [2:0] MODE_3 = 3'd3;
    localparam logic [2:0] MODE_4 = 3'd4;
    localparam logic [2:0] MODE_5 = 3'd5;
    localparam logic [2:0] MODE_6 = 3'd6;
    localparam logic [2:0] MODE_7 = 3'd7;

    localparam int CFG_BANK_MSB = 5;
    localparam int CFG_BANK_LSB = 3;
    localparam int CFG_MODE_MSB = 2;
    localparam int CFG_MODE_LSB = 0;

    localparam logic [1:0] CFG_KEY = 2'b11;

endpackage : cpc_ram_pkg
`default_nettype wire

// File: rtl/cpc_ram_map.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : cpc_ram_map
// Brief    : Combinational window-to-SRAM-page mapping from the config register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module cpc_ram_map
    import cpc_ram_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [5:0] cfg_i,
    input  logic       mreq_b_i,
    output logic       ramdis_o,
    output logic       ram_cs_b_o,
    output logic [4:0] ramadr_hi_o
);

    logic [2:0] w_mode;
    logic [2:0] w_bank;
    logic       w_ext;
    logic [1:0] w_page;

    assign w_mode = cfg_i[CFG_MODE_MSB:CFG_MODE_LSB];
    assign w_bank = cfg_i[CFG_BANK_MSB:CFG_BANK_LSB];

    always_comb begin
        w_ext  = 1'b0;
        w_page = a_i;
        case (w_mode)
            MODE_0: begin
                w_ext  = 1'b0;
                w_page = a_i;
            end
            MODE_1, MODE_3: begin
                // Mode 3 also remaps &4000 on the real machine; the host handles that.
                w_ext  = (a_i == 2'b11);
                w_page = 2'b11;
            end
            MODE_2: begin
                w_ext  = 1'b1;
                w_page = a_i;
            end
            MODE_4, MODE_5, MODE_6, MODE_7: begin
                w_ext  = (a_i == 2'b01);
                w_page = w_mode[1:0];
            end
            default: begin
                w_ext  = 1'b0;
                w_page = a_i;
            end
        endcase
    end

    assign ramadr_hi_o = w_ext ? {w_bank, w_page} : {w_bank, a_i};
    assign ramdis_o    = w_ext;
    assign ram_cs_b_o  = ~(w_ext & ~mreq_b_i);

endmodule : cpc_ram_map
`default_nettype wire

// File: rtl/cpc_ram_bank_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : cpc_ram_bank_ctrl
// Brief    : Qualifies Z80 RAM-config port writes and drives the SRAM banking pins.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module cpc_ram_bank_ctrl
    import cpc_ram_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] a_i,
    input  logic [7:0] d_i,
    input  logic       ioreq_b_i,
    input  logic       wr_b_i,
    input  logic       mreq_b_i,
    output logic [5:0] cfg_o,
    output logic       cfg_wr_o,
    output logic       ramdis_o,
    output logic       ram_cs_b_o,
    output logic [4:0] ramadr_hi_o
);

    logic       w_strobe;
    logic       sync1_q;
    logic       sync2_q;
    state_t     state_q;
    state_t     state_d;
    logic       w_load;
    logic [5:0] cfg_q;
    logic [5:0] cfg_d;
    logic       cfg_wr_q;

    // Decoded from raw pins so only one signal crosses into the clock domain.
    assign w_strobe = ~ioreq_b_i & ~wr_b_i & ~a_i[1];

    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) state_d = ST_QUAL;
            end
            ST_QUAL: begin
                if (sync2_q) begin
                    state_d = ST_HOLD;
                    w_load  = (d_i[7:6] == CFG_KEY);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!sync2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cfg_d = w_load ? d_i[5:0] : cfg_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= ST_IDLE;
            cfg_q    <= 6'h00;
            cfg_wr_q <= 1'b0;
        end else begin
            sync1_q  <= w_strobe;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            cfg_wr_q <= w_load;
        end
    end

    assign cfg_o    = cfg_q;
    assign cfg_wr_o = cfg_wr_q;

    cpc_ram_map u_map (
        .a_i         (a_i),
        .cfg_i       (cfg_q),
        .mreq_b_i    (mreq_b_i),
        .ramdis_o    (ramdis_o),
        .ram_cs_b_o  (ram_cs_b_o),
        .ramadr_hi_o (ramadr_hi_o)
    );

endmodule : cpc_ram_bank_ctrl
`default_nettype wire

// File: tb/tb_cpc_ram_bank_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module   : tb_cpc_ram_bank_ctrl
// Brief    : Directed self-checking bench for the CPC RAM bank controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_cpc_ram_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a;
    logic [7:0] d;
    logic       ioreq_b;
    logic       wr_b;
    logic       mreq_b;
    logic [5:0] cfg;
    logic       cfg_wr;
    logic       ramdis;
    logic       ram_cs_b;
    logic [4:0] ramadr_hi;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    cpc_ram_bank_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .a_i         (a),
        .d_i         (d),
        .ioreq_b_i   (ioreq_b),
        .wr_b_i      (wr_b),
        .mreq_b_i    (mreq_b),
        .cfg_o       (cfg),
        .cfg_wr_o    (cfg_wr),
        .ramdis_o    (ramdis),
        .ram_cs_b_o  (ram_cs_b),
        .ramadr_hi_o (ramadr_hi)
    );

    always #5 clk = ~clk;

    // Number of cycles in which CFG_WR was seen high.
    always @(negedge clk) if (cfg_wr === 1'b1) wr_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle(input int n);
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [1:0] wa, input logic [7:0] wd, input int n);
        a       = wa;
        d       = wd;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
        repeat (n) tick();
        bus_idle(4);
    endtask

    task automatic test_reset();
        logic [4:0] exp_adr;
        a       = 2'($urandom);
        d       = 8'($urandom);
        ioreq_b = 1'($urandom);
        wr_b    = 1'($urandom);
        mreq_b  = 1'($urandom);
        rst     = 1'b1;
        #3;
        exp_adr = {3'b000, a};
        checks++; if (cfg !== 6'h00) begin errors++; $display("FAIL reset_cfg: got %h want 00", cfg); end
        checks++; if (cfg_wr !== 1'b0) begin errors++; $display("FAIL reset_cfg_wr: got %b want 0", cfg_wr); end
        checks++; if (ramdis !== 1'b0) begin errors++; $display("FAIL reset_ramdis: got %b want 0", ramdis); end
        checks++; if (ram_cs_b !== 1'b1) begin errors++; $display("FAIL reset_cs_b: got %b want 1", ram_cs_b); end
        checks++; if (ramadr_hi !== exp_adr) begin errors++; $display("FAIL reset_adr: got %b want %b", ramadr_hi, exp_adr); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (cfg !== 6'h00) begin errors++; $display("FAIL release_cfg: got %h want 00", cfg); end
        checks++; if (cfg_wr !== 1'b0) begin errors++; $display("FAIL release_cfg_wr: got %b want 0", cfg_wr); end
        checks++; if (ram_cs_b !== 1'b1) begin errors++; $display("FAIL release_cs_b: got %b want 1", ram_cs_b); end
        mreq_b = 1'b1;
        bus_idle(4);
    endtask

    task automatic test_basic_load();
        int w0;
        w0      = wr_count;
        a       = 2'b01;
        d       = 8'hC2;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
        tick();
        checks++; if (cfg !== 6'h00) begin errors++; $display("FAIL basic_e1_cfg: got %h want 00", cfg); end
        tick();
        tick();
        checks++; if (cfg !== 6'h00) begin errors++; $display("FAIL basic_e3_cfg: got %h want 00", cfg); end
        checks++; if (cfg_wr !== 1'b0) begin errors++; $display("FAIL basic_e3_wr: got %b want 0", cfg_wr); end
        tick();
        checks++; if (cfg !== 6'h02) begin errors++; $display("FAIL basic_e4_cfg: got %h want 02", cfg); end
        checks++; if (cfg_wr !== 1'b1) begin errors++; $display("FAIL basic_e4_wr: got %b want 1", cfg_wr); end
        tick();
        checks++; if (cfg_wr !== 1'b0) begin errors++; $display("FAIL basic_e5_wr: got %b want 0", cfg_wr); end
        tick();
        bus_idle(4);
        checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", wr_count - w0); end
        a      = 2'b01;
        mreq_b = 1'b0;
        #1;
        checks++; if (ramdis !== 1'b1) begin errors++; $display("FAIL basic_w1_ramdis: got %b want 1", ramdis); end
        checks++; if (ram_cs_b !== 1'b0) begin errors++; $display("FAIL basic_w1_cs_b: got %b want 0", ram_cs_b); end
        checks++; if (ramadr_hi !== 5'b00001) begin errors++; $display("FAIL basic_w1_adr: got %b want 00001", ramadr_hi); end
        a = 2'b00;
        #1;
        // Mode 2 maps every window to the external RAM.
        checks++; if (ramdis !== 1'b1) begin errors++; $display("FAIL basic_w0_ramdis: got %b want 1", ramdis); end
        checks++; if (ramadr_hi !== 5'b00000) begin errors++; $display("FAIL basic_w0_adr: got %b want 00000", ramadr_hi); end
        mreq_b = 1'b1;
        #1;
        checks++; if (ram_cs_b !== 1'b1) begin errors++; $display("FAIL basic_mreq_hi_cs_b: got %b want 1", ram_cs_b); end
    endtask

    task automatic test_banked();
        do_write(2'b01, 8'hFD, 6);
        checks++; if (cfg !== 6'h3D) begin errors++; $display("FAIL banked_cfg: got %h want 3d", cfg); end
        a      = 2'b01;
        mreq_b = 1'b0;
        #1;
        checks++; if (ramadr_hi !== 5'b11101) begin errors++; $display("FAIL banked_w1_adr: got %b want 11101", ramadr_hi); end
        checks++; if (ramdis !== 1'b1) begin errors++; $display("FAIL banked_w1_ramdis: got %b want 1", ramdis); end
        checks++; if (ram_cs_b !== 1'b0) begin errors++; $display("FAIL banked_w1_cs_b: got %b want 0", ram_cs_b); end
        a = 2'b10;
        #1;
        checks++; if (ramdis !== 1'b0) begin errors++; $display("FAIL banked_w2_ramdis: got %b want 0", ramdis); end
        checks++; if (ram_cs_b !== 1'b1) begin errors++; $display("FAIL banked_w2_cs_b: got %b want 1", ram_cs_b); end
        checks++; if (ramadr_hi !== 5'b11110) begin errors++; $display("FAIL banked_w2_adr: got %b want 11110", ramadr_hi); end
        mreq_b = 1'b1;
        do_write(2'b01, 8'hC3, 6);
        a      = 2'b11;
        mreq_b = 1'b0;
        #1;
        checks++; if (ramdis !== 1'b1) begin errors++; $display("FAIL mode3_w3_ramdis: got %b want 1", ramdis); end
        checks++; if (ramadr_hi !== 5'b00011) begin errors++; $display("FAIL mode3_w3_adr: got %b want 00011", ramadr_hi); end
        a = 2'b01;
        #1;
        checks++; if (ramdis !== 1'b0) begin errors++; $display("FAIL mode3_w1_ramdis: got %b want 0", ramdis); end
        mreq_b = 1'b1;
    endtask

    task automatic test_reject();
        int w0;
        w0 = wr_count;
        do_write(2'b00, 8'hC5, 1);
        checks++; if (cfg !== 6'h03) begin errors++; $display("FAIL reject_short: got %h want 03", cfg); end
        do_write(2'b01, 8'h85, 6);
        checks++; if (cfg !== 6'h03) begin errors++; $display("FAIL reject_key: got %h want 03", cfg); end
        do_write(2'b10, 8'hC7, 6);
        checks++; if (cfg !== 6'h03) begin errors++; $display("FAIL reject_a15: got %h want 03", cfg); end
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL reject_pulses: got %0d want 0", wr_count - w0); end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0      = wr_count;
        a       = 2'b01;
        d       = 8'hC4;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
        repeat (20) tick();
        checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL long_pulses: got %0d want 1", wr_count - w0); end
        checks++; if (cfg !== 6'h04) begin errors++; $display("FAIL long_cfg: got %h want 04", cfg); end
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        tick();
        d       = 8'hC6;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
        tick();
        checks++; if (cfg !== 6'h04) begin errors++; $display("FAIL rep_e1_cfg: got %h want 04", cfg); end
        tick();
        tick();
        checks++; if (cfg !== 6'h04) begin errors++; $display("FAIL rep_e3_cfg: got %h want 04", cfg); end
        checks++; if (cfg_wr !== 1'b0) begin errors++; $display("FAIL rep_e3_wr: got %b want 0", cfg_wr); end
        tick();
        checks++; if (cfg !== 6'h06) begin errors++; $display("FAIL rep_e4_cfg: got %h want 06", cfg); end
        checks++; if (cfg_wr !== 1'b1) begin errors++; $display("FAIL rep_e4_wr: got %b want 1", cfg_wr); end
        tick();
        bus_idle(4);
        checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL rep_pulses: got %0d want 2", wr_count - w0); end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        w0      = wr_count;
        a       = 2'b01;
        d       = 8'hC1;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (cfg !== 6'h00) begin errors++; $display("FAIL mid_rst_cfg: got %h want 00", cfg); end
        checks++; if (cfg_wr !== 1'b0) begin errors++; $display("FAIL mid_rst_wr: got %b want 0", cfg_wr); end
        checks++; if (ramadr_hi !== 5'b00001) begin errors++; $display("FAIL mid_rst_adr: got %b want 00001", ramadr_hi); end
        tick();
        rst = 1'b0;
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL mid_rst_pulses: got %0d want 0", wr_count - w0); end
        repeat (3) tick();
        checks++; if (cfg !== 6'h00) begin errors++; $display("FAIL mid_resync_e3: got %h want 00", cfg); end
        repeat (3) tick();
        checks++; if (cfg !== 6'h01) begin errors++; $display("FAIL mid_reload_cfg: got %h want 01", cfg); end
        bus_idle(4);
        checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL mid_reload_pulses: got %0d want 1", wr_count - w0); end
    endtask

    initial begin
        rst     = 1'b1;
        a       = 2'b00;
        d       = 8'h00;
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        mreq_b  = 1'b1;
        test_reset();
        test_basic_load();
        test_banked();
        test_reject();
        test_back_to_back();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cpc_ram_bank_ctrl
`default_nettype wire
